// File: rtl/mux_arb_pkg.sv
// Shared constants for the round-robin bit-mux arbiter: requester count, idle select code
// and the FSM state encoding.
package mux_arb_pkg;

  localparam int unsigned N_REQ = 7;

  localparam logic [2:0] SEL_NONE = 3'b111;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_GRANT = 2'd1;
  localparam arb_state_t ST_GAP   = 2'd2;

  // One-hot grant vector for an owner index; SEL_NONE (or any out-of-range code) gives zero.
  function automatic logic [N_REQ-1:0] grant_onehot(input logic [2:0] idx);
    logic [N_REQ-1:0] vec;
    vec = '0;
    if (idx < 3'(N_REQ)) begin
      vec[idx] = 1'b1;
    end
    return vec;
  endfunction

endpackage

// File: rtl/select_mux7.sv
// Combinational 7:1 single-bit mux; unused select codes drive 0.
module select_mux7 (
  input  logic [2:0] sel_i,
  input  logic [6:0] data_i,
  output logic       out_o
);

  always_comb begin
    out_o = 1'b0;
    case (sel_i)
      3'd0:    out_o = data_i[0];
      3'd1:    out_o = data_i[1];
      3'd2:    out_o = data_i[2];
      3'd3:    out_o = data_i[3];
      3'd4:    out_o = data_i[4];
      3'd5:    out_o = data_i[5];
      3'd6:    out_o = data_i[6];
      default: out_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 7:1 bit mux among seven requesters; each grant lasts at most
// HOLD_CYCLES cycles and is followed by a GAP and an IDLE cycle before re-arbitration.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [6:0] Req,
  input  logic [6:0] Data,
  output logic [2:0] MuxSelect,
  output logic [6:0] Grant,
  output logic       Valid,
  output logic       Out
);

  localparam logic [3:0] CntLast = 4'(HOLD_CYCLES - 1);

  arb_state_t state_q, state_d;
  logic [2:0] owner_q, owner_d;
  logic [2:0] last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] sel_q, sel_d;
  logic [6:0] grant_q, grant_d;

  // First set request strictly after `last`, wrapping 6 -> 0; `last` itself is checked last.
  function automatic logic [2:0] rr_pick(input logic [6:0] req, input logic [2:0] last);
    logic [2:0] idx;
    logic       found;
    logic [2:0] pick;
    idx   = last;
    found = 1'b0;
    pick  = last;
    for (int k = 0; k < int'(N_REQ); k++) begin
      idx = (idx >= 3'd6) ? 3'd0 : idx + 3'd1;
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  logic [2:0] winner;
  assign winner = rr_pick(Req, last_q);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (Req != 7'd0) begin
          state_d = ST_GRANT;
          owner_d = winner;
          last_d  = winner;
          sel_d   = winner;
          grant_d = grant_onehot(winner);
          cnt_d   = 4'd0;
        end
      end
      ST_GRANT: begin
        if (!Req[owner_q] || (cnt_q == CntLast)) begin
          state_d = ST_GAP;
          sel_d   = SEL_NONE;
          grant_d = '0;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
        sel_d   = SEL_NONE;
        grant_d = '0;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = SEL_NONE;
        grant_d = '0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      owner_q <= 3'd0;
      last_q  <= 3'd6;
      cnt_q   <= 4'd0;
      sel_q   <= SEL_NONE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
    end
  end

  assign MuxSelect = sel_q;
  assign Grant     = grant_q;
  assign Valid     = (state_q == ST_GRANT);

  select_mux7 u_select_mux7 (
    .sel_i  (sel_q),
    .data_i (Data),
    .out_o  (Out)
  );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: a cycle-level ownership model predicts who holds the mux
// after each edge; a separate monitor compares the DUT outputs against those predictions.
module tb_mux_rr_arbiter;

  localparam int H = 4;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [6:0] Req   = 7'd0;
  logic [6:0] Data  = 7'd0;
  logic [2:0] MuxSelect;
  logic [6:0] Grant;
  logic       Valid;
  logic       Out;

  mux_rr_arbiter #(.HOLD_CYCLES(H)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Req       (Req),
    .Data      (Data),
    .MuxSelect (MuxSelect),
    .Grant     (Grant),
    .Valid     (Valid),
    .Out       (Out)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc = cyc + 1;

  typedef struct {
    int cyc;
    int owner;  // -1 when nobody holds the mux
  } exp_t;

  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  // Model: who owns the mux, for how many cycles so far, and whether a release cooldown is due.
  int m_owner = -1;
  int m_held  = 0;
  int m_last  = 6;
  bit m_cool  = 1'b0;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  task automatic step(input bit rst, input logic [6:0] req, input logic [6:0] data);
    exp_t e;
    @(posedge Clock);
    #1;
    Reset = rst;
    Req   = req;
    Data  = data;
    if (rst) begin
      m_owner = -1;
      m_held  = 0;
      m_last  = 6;
      m_cool  = 1'b0;
    end else if (m_owner >= 0) begin
      if (!req[m_owner] || m_held == H) begin
        m_owner = -1;
        m_held  = 0;
        m_cool  = 1'b1;
      end else begin
        m_held++;
      end
    end else if (m_cool) begin
      m_cool = 1'b0;
    end else if (req != 7'd0) begin
      for (int k = 1; k <= 7; k++) begin
        if (m_owner < 0 && req[(m_last + k) % 7]) m_owner = (m_last + k) % 7;
      end
      m_last = m_owner;
      m_held = 1;
    end
    e.cyc   = cyc + 1;
    e.owner = m_owner;
    exp_q.push_back(e);
  endtask

  task automatic hold(input int n, input bit rst, input logic [6:0] req, input logic [6:0] data);
    for (int i = 0; i < n; i++) step(rst, req, data);
  endtask

  // Monitor: checks each predicted cycle in the middle of that cycle.
  initial begin
    exp_t e;
    int   w_sel;
    int   w_gnt;
    int   w_out;
    forever begin
      @(negedge Clock);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e     = exp_q.pop_front();
        w_sel = (e.owner < 0) ? 7 : e.owner;
        w_gnt = (e.owner < 0) ? 0 : (1 << e.owner);
        w_out = (e.owner < 0) ? 0 : int'(Data[e.owner]);
        chk("MuxSelect", int'(MuxSelect), w_sel);
        chk("Grant", int'(Grant), w_gnt);
        chk("Valid", int'(Valid), (e.owner >= 0) ? 1 : 0);
        chk("Out", int'(Out), w_out);
      end
    end
  end

  initial begin
    logic [6:0] r;
    // Reset then idle.
    hold(2, 1'b1, 7'd0, 7'd0);
    hold(5, 1'b0, 7'd0, 7'h55);
    // Single requester held: 4-cycle grants, GAP + IDLE between.
    hold(1, 1'b1, 7'd0, 7'd0);
    hold(14, 1'b0, 7'b0000100, 7'b0000100);
    // Two requesters alternate 0, 6, 0, 6.
    hold(1, 1'b1, 7'd0, 7'd0);
    hold(26, 1'b0, 7'b1000001, 7'b1000001);
    // Short request: 2-cycle grant, no further grant.
    hold(1, 1'b1, 7'd0, 7'd0);
    hold(2, 1'b0, 7'd0, 7'd0);
    hold(2, 1'b0, 7'b0001000, 7'b0001000);
    hold(6, 1'b0, 7'd0, 7'b0001000);
    // Wrap: after a grant to 6, requesters 1 and 6 -> 1 wins.
    hold(1, 1'b1, 7'd0, 7'd0);
    hold(2, 1'b0, 7'b1000000, 7'b1000000);
    hold(3, 1'b0, 7'd0, 7'd0);
    hold(6, 1'b0, 7'b1000010, 7'b0000010);
    // Full request with reset mid-grant.
    hold(1, 1'b1, 7'd0, 7'd0);
    hold(1, 1'b0, 7'b1111111, 7'b0101010);
    hold(1, 1'b1, 7'd0, 7'd0);
    hold(1, 1'b0, 7'b1111111, 7'b0101010);
    hold(1, 1'b0, 7'b1111111, 7'b0101010);
    hold(1, 1'b1, 7'b1111111, 7'b0101010);
    hold(8, 1'b0, 7'b1111111, 7'b1010101);
    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      r = 7'($urandom) & 7'($urandom);
      if ($urandom_range(0, 3) == 0) r = r | 7'($urandom);
      step(($urandom_range(0, 79) == 0), r, 7'($urandom));
    end
    hold(4, 1'b0, 7'd0, 7'd0);
    repeat (3) @(posedge Clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0 pending", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
